adc_capture_host: RTL and testbench

Sample-capture block for the ADC input path, the receive-side counterpart of the DDS/DAC output path. Samples the 8-bit parallel ADC bus once per clock and decimates the stream by a programmable ratio. On a level-crossing trigger it stores DEPTH consecutive decimated samples in an internal RAM, then streams them out over a valid/ready interface to the host readout logic.

---
 rtl/adc_capture_host_if.sv | 22 ++
 rtl/adc_capture_host.sv | 192 +++++++++++++++++++
 tb/tb_adc_capture_host.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/adc_capture_host_if.sv
// Readout port of the ADC capture block: valid/ready sample stream.
// master drives samples, slave consumes them.
interface adc_capture_host_if;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_last;
    logic       rd_ready;

    modport master (
        output rd_data,
        output rd_valid,
        output rd_last,
        input  rd_ready
    );

    modport slave (
        input  rd_data,
        input  rd_valid,
        input  rd_last,
        output rd_ready
    );
endinterface

// File: rtl/adc_capture_host.sv
// ADC capture: decimate, level-trigger, store DEPTH samples, stream out.
// Optional auto-trigger timeout: define ADC_CAPTURE_TIMEOUT_EN.
module adc_capture_host #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
`ifdef ADC_CAPTURE_TIMEOUT_EN
    ,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
`endif
) (
    input  logic                       Clk,
    input  logic                       Rst,
    output logic                       AD_Clk,
    input  logic [7:0]                 AD_Data,
    input  logic [15:0]                decim_in,
    input  logic [1:0]                 trig_mode_in,
    input  logic [7:0]                 trig_level_in,
    input  logic                       arm,
    input  logic                       abort,
    output logic                       busy,
    output logic                       done,
    adc_capture_host_if.master         rd
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_TRIG = 2'd1;
    localparam logic [1:0] CAPTURE   = 2'd2;
    localparam logic [1:0] READOUT   = 2'd3;

    logic [1:0]        state;
    logic [7:0]        s0;
    logic [7:0]        prev;
    logic              prev_valid;
    logic [7:0]        level;
    logic [1:0]        mode;
    logic [15:0]       decim;
    logic [15:0]       cnt;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] wr_nxt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   ra;
    logic [7:0]        mem [0:DEPTH-1];
    logic [7:0]        q;
    logic              q_vld;
    logic              q_last;

    logic stb, rise, fall, hit, trig, to_hit;
    logic wr_en, last_wr, adv, issue, fire_last;

    assign AD_Clk = ~Clk;
    assign busy   = (state != IDLE);

    assign stb  = (cnt == 16'd0);
    assign rise = prev_valid && (prev < level) && (s0 >= level);
    assign fall = prev_valid && (prev >= level) && (s0 < level);

    always_comb begin
        hit = 1'b0;
        case (mode)
            2'd0:    hit = 1'b1;
            2'd1:    hit = rise;
            2'd2:    hit = fall;
            default: hit = rise | fall;
        endcase
    end

`ifdef ADC_CAPTURE_TIMEOUT_EN
    logic [23:0] to_cnt;

    // Cleared whenever idle, so every entry into WAIT_TRIG starts from zero.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            to_cnt <= 24'd0;
        else if (state != WAIT_TRIG)
            to_cnt <= 24'd0;
        else if (!to_hit)
            to_cnt <= to_cnt + 24'd1;
    end

    assign to_hit = (to_cnt >= TIMEOUT_CYCLES);
`else
    assign to_hit = 1'b0;
`endif

    assign trig    = stb && (hit || to_hit);
    assign wr_nxt  = wr_addr + ADDR_W'(1);
    assign wr_ptr  = (state == WAIT_TRIG) ? '0 : wr_nxt;
    assign wr_en   = ((state == WAIT_TRIG) && trig) ||
                     ((state == CAPTURE) && stb);
    assign last_wr = (wr_nxt == ADDR_W'(DEPTH - 1));

    // Two-stage read pipe: RAM output reg feeds the output reg.
    assign adv       = !rd.rd_valid || rd.rd_ready;
    assign issue     = (state == READOUT) && (!q_vld || adv) && !ra[ADDR_W];
    assign fire_last = rd.rd_valid && rd.rd_ready && rd.rd_last;

    always_ff @(posedge Clk) begin
        if (wr_en)
            mem[wr_ptr] <= s0;
        if (issue)
            q <= mem[ra[ADDR_W-1:0]];
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state       <= IDLE;
            s0          <= 8'h00;
            prev        <= 8'h00;
            prev_valid  <= 1'b0;
            level       <= 8'h00;
            mode        <= 2'd0;
            decim       <= 16'd0;
            cnt         <= 16'd0;
            wr_addr     <= '0;
            ra          <= '0;
            q_vld       <= 1'b0;
            q_last      <= 1'b0;
            done        <= 1'b0;
            rd.rd_data  <= 8'h00;
            rd.rd_valid <= 1'b0;
            rd.rd_last  <= 1'b0;
        end else begin
            s0   <= AD_Data;
            done <= 1'b0;

            if (state == IDLE && arm && !abort)
                cnt <= decim_in;
            else if (state != IDLE)
                cnt <= stb ? decim : cnt - 16'd1;

            if (abort) begin
                state       <= IDLE;
                rd.rd_valid <= 1'b0;
                q_vld       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (arm) begin
                            state      <= WAIT_TRIG;
                            decim      <= decim_in;
                            mode       <= trig_mode_in;
                            level      <= trig_level_in;
                            prev_valid <= 1'b0;
                            wr_addr    <= '0;
                        end
                    end
                    WAIT_TRIG: begin
                        if (stb) begin
                            prev       <= s0;
                            prev_valid <= 1'b1;
                            if (trig) begin
                                state   <= CAPTURE;
                                wr_addr <= '0;
                            end
                        end
                    end
                    CAPTURE: begin
                        if (stb) begin
                            wr_addr <= wr_nxt;
                            if (last_wr) begin
                                state <= READOUT;
                                ra    <= '0;
                            end
                        end
                    end
                    default: begin
                        if (issue) begin
                            q_vld  <= 1'b1;
                            q_last <= (ra[ADDR_W-1:0] == ADDR_W'(DEPTH - 1));
                            ra     <= ra + (ADDR_W+1)'(1);
                        end else if (adv) begin
                            q_vld <= 1'b0;
                        end
                        if (adv) begin
                            rd.rd_valid <= q_vld;
                            rd.rd_data  <= q;
                            rd.rd_last  <= q_last;
                        end
                        if (fire_last) begin
                            state       <= IDLE;
                            done        <= 1'b1;
                            rd.rd_valid <= 1'b0;
                            rd.rd_last  <= 1'b0;
                            q_vld       <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_capture_host.sv
// Directed bench for adc_capture_host: trigger modes, decimation,
// stalled readout, abort and mid-readout reset.
module tb_adc_capture_host;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        AD_Clk;
    logic [7:0]  AD_Data = 8'h00;
    logic [15:0] decim_in = 16'd0;
    logic [1:0]  trig_mode_in = 2'd0;
    logic [7:0]  trig_level_in = 8'h00;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;

    adc_capture_host_if rd_if ();

    adc_capture_host dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .AD_Clk       (AD_Clk),
        .AD_Data      (AD_Data),
        .decim_in     (decim_in),
        .trig_mode_in (trig_mode_in),
        .trig_level_in(trig_level_in),
        .arm          (arm),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .rd           (rd_if.master)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int t = 0;
    int wsel = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] wave(input int s);
        int v;
        case (wsel)
            0:       v = s;
            1:       v = (s <= 255) ? s : 510 - s;
            default: v = 16;
        endcase
        return v[7:0];
    endfunction

    function automatic logic [7:0] exp_val(input int kind, input int i);
        int v;
        case (kind)
            0:       v = i;
            1:       v = (128 + i <= 255) ? 128 + i : 510 - (128 + i);
            default: v = 3 + 4 * i;
        endcase
        return v[7:0];
    endfunction

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic step();
        @(posedge Clk);
        #1;
        t++;
        AD_Data = wave(t);
    endtask

    task automatic do_arm(input int w, input logic [1:0] m,
                          input logic [7:0] lvl, input logic [15:0] dec);
        wsel = w;
        trig_mode_in = m;
        trig_level_in = lvl;
        decim_in = dec;
        t = 0;
        AD_Data = wave(0);
        arm = 1'b1;
        step();
        arm = 1'b0;
        chk("busy_after_arm", busy, 1);
    endtask

    task automatic read_all(input int kind, input bit rnd);
        int idx = 0;
        int n = 0;
        while (idx < 256 && n < 4000) begin
            rd_if.rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rd_if.rd_valid)
                chk("rd_data", rd_if.rd_data, exp_val(kind, idx));
            if (rd_if.rd_valid && rd_if.rd_ready) begin
                chk("rd_last", rd_if.rd_last, (idx == 255) ? 1 : 0);
                idx++;
            end
            step();
            n++;
        end
        chk("read_cnt", idx, 256);
        chk("done_hi", done, 1);
        chk("busy_end", busy, 0);
        rd_if.rd_ready = 1'b0;
        step();
        chk("done_pulse", done, 0);
        chk("valid_end", rd_if.rd_valid, 0);
    endtask

    initial begin
        bit ok_busy, ok_valid, saw_done;
        rd_if.rd_ready = 1'b0;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", rd_if.rd_valid, 0);
        chk("rst_last", rd_if.rd_last, 0);
        chk("rst_data", rd_if.rd_data, 0);
        repeat (2) step();
        Rst = 1'b0;
        repeat (2) step();
        chk("idle_busy", busy, 0);

        // Immediate trigger on ramp, with first-valid latency
        do_arm(0, 2'd0, 8'h00, 16'd0);
        repeat (257) step();
        chk("valid_early", rd_if.rd_valid, 0);
        step();
        chk("valid_lat", rd_if.rd_valid, 1);
        read_all(0, 0);

        // Rising edge on triangle, level 0x80
        do_arm(1, 2'd1, 8'h80, 16'd0);
        read_all(1, 0);

        // Decimate by 4 with random stalls
        do_arm(0, 2'd0, 8'h00, 16'd3);
        read_all(2, 1);

        // Falling mode on constant input never triggers
        do_arm(2, 2'd2, 8'h40, 16'd0);
        ok_busy = 1'b1;
        ok_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (!busy) ok_busy = 1'b0;
            if (rd_if.rd_valid) ok_valid = 1'b0;
        end
        chk("wait_busy", ok_busy, 1);
        chk("wait_novalid", ok_valid, 0 + 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_wait", busy, 0);

        // Abort during capture, then a clean re-arm
        do_arm(0, 2'd0, 8'h00, 16'd0);
        repeat (100) step();
        chk("cap_busy", busy, 1);
        abort = 1'b1;
        arm = 1'b1;
        step();
        abort = 1'b0;
        arm = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        saw_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done || busy) saw_done = 1'b1;
        end
        chk("abort_quiet", saw_done, 0);
        do_arm(0, 2'd0, 8'h00, 16'd0);
        read_all(0, 1);

        // Reset in the middle of readout
        do_arm(0, 2'd0, 8'h00, 16'd0);
        rd_if.rd_ready = 1'b1;
        repeat (300) step();
        chk("pre_rst_valid", rd_if.rd_valid, 1);
        #2;
        Rst = 1'b1;
        #1;
        chk("mid_rst_valid", rd_if.rd_valid, 0);
        chk("mid_rst_last", rd_if.rd_last, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_data", rd_if.rd_data, 0);
        step();
        chk("rst_hold_busy", busy, 0);
        Rst = 1'b0;
        repeat (3) step();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_valid", rd_if.rd_valid, 0);
        rd_if.rd_ready = 1'b0;
        do_arm(0, 2'd0, 8'h00, 16'd0);
        read_all(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
